// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command parser and related logic.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_READ    = 3'd0,
        CMD_WRITE   = 3'd1,
        CMD_ADDR    = 3'd2,
        CMD_SPECIAL = 3'd3,
        CMD_TEST    = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BADCHAR  = 3'd1,
        ERR_OVERFLOW = 3'd2,
        ERR_OVERRUN  = 3'd3,
        ERR_ORPHAN   = 3'd4,
        ERR_TIMEOUT  = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        BC_DIGIT,
        BC_CMD,
        BC_TERM,
        BC_SPACE,
        BC_BAD
    } byte_class_e;

    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_9     = 8'h39;
    localparam logic [7:0] CHR_LOW_A = 8'h61;
    localparam logic [7:0] CHR_LOW_F = 8'h66;
    localparam logic [7:0] CHR_R     = 8'h52;
    localparam logic [7:0] CHR_W     = 8'h57;
    localparam logic [7:0] CHR_A     = 8'h41;
    localparam logic [7:0] CHR_S     = 8'h53;
    localparam logic [7:0] CHR_T     = 8'h54;
    localparam logic [7:0] CHR_E     = 8'h45;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_SP    = 8'h20;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte input, command output handshake and error reporting of the parser.
interface uart_cmd_parser_if #(
    parameter int DATA_W = 32
);
    import uart_cmd_pkg::*;

    localparam int NDW = $clog2(DATA_W / 4 + 1);

    logic [7:0]        i_rx_data;
    logic              i_rx_stb;
    logic              o_cmd_valid;
    logic              i_cmd_ready;
    cmd_e              o_cmd;
    logic [DATA_W-1:0] o_cmd_word;
    logic [NDW-1:0]    o_cmd_ndigits;
    logic              o_err_stb;
    err_e              o_err_code;
    logic              o_busy;

    // Parser side.
    modport slave (
        input  i_rx_data, i_rx_stb, i_cmd_ready,
        output o_cmd_valid, o_cmd, o_cmd_word, o_cmd_ndigits,
        output o_err_stb, o_err_code, o_busy
    );

    // Byte source / command consumer side.
    modport master (
        output i_rx_data, i_rx_stb, i_cmd_ready,
        input  o_cmd_valid, o_cmd, o_cmd_word, o_cmd_ndigits,
        input  o_err_stb, o_err_code, o_busy
    );

endinterface

// File: rtl/uart_cmd_classify.sv
// Combinational ASCII byte decoder: byte class, hex nibble and command code.
module uart_cmd_classify
    import uart_cmd_pkg::*;
(
    input  logic [7:0]  byte_i,
    output byte_class_e cls_o,
    output logic [3:0]  nibble_o,
    output cmd_e        cmd_o
);

    // Full 8-bit compare, so any byte with bit 7 set falls through to BAD.
    always_comb begin
        cls_o    = BC_BAD;
        nibble_o = 4'd0;
        cmd_o    = CMD_READ;
        if (byte_i >= CHR_0 && byte_i <= CHR_9) begin
            cls_o    = BC_DIGIT;
            nibble_o = byte_i[3:0];
        end else if (byte_i >= CHR_LOW_A && byte_i <= CHR_LOW_F) begin
            cls_o    = BC_DIGIT;
            nibble_o = byte_i[3:0] + 4'd9;
        end else begin
            case (byte_i)
                CHR_R:  begin cls_o = BC_CMD; cmd_o = CMD_READ;    end
                CHR_W:  begin cls_o = BC_CMD; cmd_o = CMD_WRITE;   end
                CHR_A:  begin cls_o = BC_CMD; cmd_o = CMD_ADDR;    end
                CHR_S:  begin cls_o = BC_CMD; cmd_o = CMD_SPECIAL; end
                CHR_T:  begin cls_o = BC_CMD; cmd_o = CMD_TEST;    end
                CHR_E, CHR_CR, CHR_LF: cls_o = BC_TERM;
                CHR_SP: cls_o = BC_SPACE;
                default: cls_o = BC_BAD;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: command letter + up to DATA_W/4 hex digits + terminator,
// with one-deep output buffering, inter-byte timeout and error pulses.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    uart_cmd_parser_if.slave bus
);

    localparam int MAX_DIGITS = DATA_W / 4;
    localparam int NDW        = $clog2(MAX_DIGITS + 1);
    localparam int TW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TMO_EN     = (TIMEOUT_CYC > 0);
    // Expiry is taken when the counter would step onto TIMEOUT_CYC.
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [NDW-1:0] CNT_MAX  = NDW'(MAX_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD} state_e;

    state_e            state_q, state_d;
    cmd_e              code_q, code_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [NDW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              valid_q, valid_d;
    cmd_e              ocmd_q, ocmd_d;
    logic [DATA_W-1:0] oword_q, oword_d;
    logic [NDW-1:0]    ond_q, ond_d;
    logic              err_stb_q, err_stb_d;
    err_e              err_code_q, err_code_d;

    byte_class_e byte_cls;
    logic [3:0]  nibble;
    cmd_e        byte_cmd;

    logic complete, start, err_set, tmo_expire;
    err_e err_new;

    uart_cmd_classify u_classify (
        .byte_i   (bus.i_rx_data),
        .cls_o    (byte_cls),
        .nibble_o (nibble),
        .cmd_o    (byte_cmd)
    );

    assign tmo_expire = TMO_EN && (state_q != S_IDLE) && !bus.i_rx_stb && (tmo_q == TMO_LAST);

    // Next-state logic: byte handling, command completion and error selection.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        valid_d    = valid_q;
        ocmd_d     = ocmd_q;
        oword_d    = oword_q;
        ond_d      = ond_q;
        err_stb_d  = 1'b0;
        err_code_d = err_code_q;
        complete   = 1'b0;
        start      = 1'b0;
        err_set    = 1'b0;
        err_new    = ERR_NONE;

        if (valid_q && bus.i_cmd_ready) valid_d = 1'b0;

        if (state_q == S_IDLE || bus.i_rx_stb) tmo_d = '0;
        else if (tmo_q != TMO_LAST)            tmo_d = tmo_q + TW'(1);

        if (bus.i_rx_stb) begin
            case (state_q)
                S_IDLE: begin
                    case (byte_cls)
                        BC_CMD:   start = 1'b1;
                        BC_DIGIT: begin err_set = 1'b1; err_new = ERR_ORPHAN;  end
                        BC_BAD:   begin err_set = 1'b1; err_new = ERR_BADCHAR; end
                        default: ;
                    endcase
                end
                S_ACCUM: begin
                    case (byte_cls)
                        BC_DIGIT: begin
                            if (cnt_q == CNT_MAX) begin
                                err_set = 1'b1;
                                err_new = ERR_OVERFLOW;
                                state_d = S_DISCARD;
                            end else begin
                                acc_d = (acc_q << 4) | DATA_W'(nibble);
                                cnt_d = cnt_q + NDW'(1);
                            end
                        end
                        BC_TERM: begin complete = 1'b1; state_d = S_IDLE; end
                        BC_CMD:  begin complete = 1'b1; start = 1'b1; end
                        BC_BAD:  begin err_set = 1'b1; err_new = ERR_BADCHAR; state_d = S_IDLE; end
                        default: ;
                    endcase
                end
                S_DISCARD: begin
                    case (byte_cls)
                        BC_TERM: state_d = S_IDLE;
                        BC_CMD:  start = 1'b1;
                        default: ;
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_expire) begin
            err_set = 1'b1;
            err_new = ERR_TIMEOUT;
            state_d = S_IDLE;
        end

        // Completion reads the old command fields, so a new command may start in the same cycle.
        if (complete) begin
            if (!valid_q || bus.i_cmd_ready) begin
                valid_d = 1'b1;
                ocmd_d  = code_q;
                oword_d = acc_q;
                ond_d   = cnt_q;
            end else begin
                err_set = 1'b1;
                err_new = ERR_OVERRUN;
            end
        end

        if (start) begin
            code_d  = byte_cmd;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ACCUM;
        end

        if (err_set) begin
            err_stb_d  = 1'b1;
            err_code_d = err_new;
        end
    end

    // State, accumulator, timeout counter and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            code_q     <= CMD_READ;
            acc_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            valid_q    <= 1'b0;
            ocmd_q     <= CMD_READ;
            oword_q    <= '0;
            ond_q      <= '0;
            err_stb_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            ocmd_q     <= ocmd_d;
            oword_q    <= oword_d;
            ond_q      <= ond_d;
            err_stb_q  <= err_stb_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.o_cmd_valid   = valid_q;
    assign bus.o_cmd         = ocmd_q;
    assign bus.o_cmd_word    = oword_q;
    assign bus.o_cmd_ndigits = ond_q;
    assign bus.o_err_stb     = err_stb_q;
    assign bus.o_err_code    = err_code_q;
    assign bus.o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a 32-bit instance with a 100-cycle timeout and a
// 16-bit instance without timeout, checked through scoreboard queues.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] word;
        logic [3:0]  nd;
    } exp_cmd_t;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    exp_cmd_t   exp_cmd32[$];
    exp_cmd_t   exp_cmd16[$];
    logic [2:0] exp_err32[$];
    logic [2:0] exp_err16[$];

    exp_cmd_t   mc32, mc16;
    logic [2:0] me32, me16;

    uart_cmd_parser_if #(.DATA_W(32)) bus32 ();
    uart_cmd_parser_if #(.DATA_W(16)) bus16 ();

    uart_cmd_parser #(.DATA_W(32), .TIMEOUT_CYC(100)) dut32 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus32.slave)
    );

    uart_cmd_parser #(.DATA_W(16), .TIMEOUT_CYC(0)) dut16 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 drives the 32-bit instance, 1 the 16-bit instance.
    task automatic send_byte(input int which, input logic [7:0] b);
        if (which == 0) begin
            bus32.i_rx_data = b;
            bus32.i_rx_stb  = 1'b1;
        end else begin
            bus16.i_rx_data = b;
            bus16.i_rx_stb  = 1'b1;
        end
        @(posedge clk);
        #1;
        bus32.i_rx_stb = 1'b0;
        bus16.i_rx_stb = 1'b0;
    endtask

    task automatic send_str(input int which, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(which, s[i]);
    endtask

    task automatic exp_c(input int which, input logic [2:0] c, input logic [31:0] w, input logic [3:0] nd);
        exp_cmd_t e;
        e.cmd  = c;
        e.word = w;
        e.nd   = nd;
        if (which == 0) exp_cmd32.push_back(e);
        else            exp_cmd16.push_back(e);
    endtask

    task automatic exp_e(input int which, input logic [2:0] code);
        if (which == 0) exp_err32.push_back(code);
        else            exp_err16.push_back(code);
    endtask

    // Scoreboard for the 32-bit instance: transfers and error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus32.o_cmd_valid && bus32.i_cmd_ready) begin
                check_eq("cmd32_expected", 64'(exp_cmd32.size() != 0), 64'd1);
                if (exp_cmd32.size() != 0) begin
                    mc32 = exp_cmd32.pop_front();
                    check_eq("cmd32_code", 64'(bus32.o_cmd), 64'(mc32.cmd));
                    check_eq("cmd32_word", 64'(bus32.o_cmd_word), 64'(mc32.word));
                    check_eq("cmd32_ndig", 64'(bus32.o_cmd_ndigits), 64'(mc32.nd));
                end
            end
            if (bus32.o_err_stb) begin
                check_eq("err32_expected", 64'(exp_err32.size() != 0), 64'd1);
                if (exp_err32.size() != 0) begin
                    me32 = exp_err32.pop_front();
                    check_eq("err32_code", 64'(bus32.o_err_code), 64'(me32));
                end
            end
        end
    end

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus16.o_cmd_valid && bus16.i_cmd_ready) begin
                check_eq("cmd16_expected", 64'(exp_cmd16.size() != 0), 64'd1);
                if (exp_cmd16.size() != 0) begin
                    mc16 = exp_cmd16.pop_front();
                    check_eq("cmd16_code", 64'(bus16.o_cmd), 64'(mc16.cmd));
                    check_eq("cmd16_word", 64'(bus16.o_cmd_word), 64'(mc16.word));
                    check_eq("cmd16_ndig", 64'(bus16.o_cmd_ndigits), 64'(mc16.nd));
                end
            end
            if (bus16.o_err_stb) begin
                check_eq("err16_expected", 64'(exp_err16.size() != 0), 64'd1);
                if (exp_err16.size() != 0) begin
                    me16 = exp_err16.pop_front();
                    check_eq("err16_code", 64'(bus16.o_err_code), 64'(me16));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero32(input string tag);
        check_eq({tag, "_valid"}, 64'(bus32.o_cmd_valid), 64'd0);
        check_eq({tag, "_cmd"},   64'(bus32.o_cmd), 64'd0);
        check_eq({tag, "_word"},  64'(bus32.o_cmd_word), 64'd0);
        check_eq({tag, "_ndig"},  64'(bus32.o_cmd_ndigits), 64'd0);
        check_eq({tag, "_estb"},  64'(bus32.o_err_stb), 64'd0);
        check_eq({tag, "_ecode"}, 64'(bus32.o_err_code), 64'd0);
        check_eq({tag, "_busy"},  64'(bus32.o_busy), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus32.i_rx_data = 8'h00; bus32.i_rx_stb = 1'b0; bus32.i_cmd_ready = 1'b1;
        bus16.i_rx_data = 8'h00; bus16.i_rx_stb = 1'b0; bus16.i_cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        tick(3);
        check_all_zero32("reset");
        check_eq("reset16_valid", 64'(bus16.o_cmd_valid), 64'd0);
        rst = 1'b0;
        tick(2);

        // Full-width argument; valid appears one cycle after 'E'.
        exp_c(0, CMD_ADDR, 32'h1234ABCD, 4'd8);
        send_str(0, "A1234abcd");
        check_eq("a_busy", 64'(bus32.o_busy), 64'd1);
        check_eq("a_valid_pre", 64'(bus32.o_cmd_valid), 64'd0);
        send_byte(0, 8'h45);
        check_eq("a_valid_post", 64'(bus32.o_cmd_valid), 64'd1);
        check_eq("a_idle", 64'(bus32.o_busy), 64'd0);
        tick(2);

        // No-argument command terminated by CR.
        exp_c(0, CMD_READ, 32'h0, 4'd0);
        send_str(0, "R\r");
        tick(2);

        // Command letter completes the previous command.
        exp_c(0, CMD_ADDR, 32'h10, 4'd2);
        exp_c(0, CMD_WRITE, 32'h5, 4'd1);
        send_str(0, "A10W");
        check_eq("chain_valid", 64'(bus32.o_cmd_valid), 64'd1);
        check_eq("chain_cmd", 64'(bus32.o_cmd), 64'(CMD_ADDR));
        send_str(0, "5E");
        check_eq("chain_valid2", 64'(bus32.o_cmd_valid), 64'd1);
        tick(2);

        // Spaces inside a command are ignored.
        exp_c(0, CMD_TEST, 32'h12, 4'd2);
        send_str(0, "T1 2\n");
        tick(2);

        // 16-bit: fifth digit overflows, then discard until terminator.
        exp_e(1, ERR_OVERFLOW);
        send_str(1, "W1234");
        send_byte(1, "5");
        check_eq("ovf_stb", 64'(bus16.o_err_stb), 64'd1);
        check_eq("ovf_code", 64'(bus16.o_err_code), 64'(ERR_OVERFLOW));
        send_str(1, "E");
        tick(1);
        check_eq("ovf_nocmd", 64'(bus16.o_cmd_valid), 64'd0);
        exp_c(1, CMD_READ, 32'h7, 4'd1);
        send_str(1, "R7E");
        tick(1);
        exp_c(1, CMD_WRITE, 32'hFFFF, 4'd4);
        send_str(1, "Wffff\n");
        tick(2);

        // Overrun: second command dropped while the first is held.
        bus16.i_cmd_ready = 1'b0;
        exp_c(1, CMD_READ, 32'h1, 4'd1);
        send_str(1, "R1E");
        exp_e(1, ERR_OVERRUN);
        send_str(1, "R2E");
        check_eq("ovr_stb", 64'(bus16.o_err_stb), 64'd1);
        check_eq("ovr_code", 64'(bus16.o_err_code), 64'(ERR_OVERRUN));
        tick(3);
        check_eq("ovr_held_valid", 64'(bus16.o_cmd_valid), 64'd1);
        check_eq("ovr_held_word", 64'(bus16.o_cmd_word), 64'h1);
        bus16.i_cmd_ready = 1'b1;
        tick(1);
        check_eq("ovr_drained", 64'(bus16.o_cmd_valid), 64'd0);
        tick(2);

        // Bad characters, orphan digit, harmless terminators in IDLE.
        exp_e(0, ERR_BADCHAR);
        send_str(0, "Wx");
        check_eq("bad_idle", 64'(bus32.o_busy), 64'd0);
        check_eq("bad_code", 64'(bus32.o_err_code), 64'(ERR_BADCHAR));
        exp_e(0, ERR_ORPHAN);
        send_str(0, "5");
        check_eq("orphan_code", 64'(bus32.o_err_code), 64'(ERR_ORPHAN));
        exp_e(0, ERR_BADCHAR);
        send_byte(0, 8'hB0);
        send_str(0, "\n\r E");
        tick(3);

        // Timeout: counter reaches 100 on the 100th edge after '2'; pulse visible then.
        exp_e(0, ERR_TIMEOUT);
        send_str(0, "A12");
        n = 0;
        while (!bus32.o_err_stb && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("tmo_latency", 64'(n), 64'd100);
        check_eq("tmo_idle", 64'(bus32.o_busy), 64'd0);
        tick(2);

        // A byte landing on the expiry edge keeps the command alive.
        exp_c(0, CMD_WRITE, 32'h3, 4'd1);
        send_str(0, "W");
        tick(99);
        send_str(0, "3E");
        tick(2);

        // Reset mid-command drops everything without an error pulse.
        send_str(0, "W3");
        rst = 1'b1;
        tick(2);
        check_all_zero32("midrst");
        rst = 1'b0;
        tick(1);
        exp_c(0, CMD_READ, 32'h1, 4'd1);
        send_str(0, "R1E");
        tick(5);

        check_eq("left_cmd32", 64'(exp_cmd32.size()), 64'd0);
        check_eq("left_err32", 64'(exp_err32.size()), 64'd0);
        check_eq("left_cmd16", 64'(exp_cmd16.size()), 64'd0);
        check_eq("left_err16", 64'(exp_err16.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parametrised ASCII command parser between the UART receiver and the bus-master/command logic. It consumes received bytes, recognises command letters, accumulates hex digits into a DATA_W-bit word and emits {command, word, digit count} on a valid/ready output. It adds explicit terminators, an overflow check, an inter-byte timeout, an output handshake and error reporting.

## Interface
- DATA_W, 32, payload width in bits; a multiple of 4, from 4 to 64; MAX_DIGITS = DATA_W/4.
- TIMEOUT_CYC, 0, idle cycles allowed between bytes inside a command; 0 disables the timeout.

Ports:
- i_clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte; sampled only when i_rx_stb is high.
- i_rx_stb  in  1  one-cycle byte-valid strobe from the UART receiver.
- o_cmd_valid  out  1  command available.
- i_cmd_ready  in  1  consumer accepts the command.
- o_cmd  out  3  command code (cmd_e).
- o_cmd_word  out  DATA_W  right-aligned, zero-extended hex value.
- o_cmd_ndigits  out  $clog2(MAX_DIGITS+1)  number of digits received (0 means no argument).
- o_err_stb  out  1  one-cycle error pulse.
- o_err_code  out  3  error cause; valid while o_err_stb is high and held afterwards.
- o_busy  out  1  high when the parser is not in IDLE.

## Operation
- Byte classes. All 8 bits are compared; bit 7 set means BAD.
  - Hex digits: '0'-'9' (0x30-0x39) and 'a'-'f' (0x61-0x66).
  - Commands: 'R'=READ(0), 'W'=WRITE(1), 'A'=ADDR(2), 'S'=SPECIAL(3), 'T'=TEST(4).
  - Terminators: 'E' (0x45), CR (0x0D), LF (0x0A).
  - Space (0x20): ignored in every state.
  - Everything else is BAD.
- State IDLE:
  - Command: latch the code, clear the accumulator and digit count, go to ACCUM.
  - Terminator: ignored, so CRLF pairs are harmless.
  - Digit: ERR_ORPHAN.
  - BAD: ERR_BADCHAR.
  - Remain in IDLE for terminators, digits and BAD bytes.
- State ACCUM:
  - Digit with count < MAX_DIGITS: acc <= {acc[DATA_W-5:0], nibble}; count++.
  - Digit with count == MAX_DIGITS: ERR_OVERFLOW, go to DISCARD.
  - Terminator: complete the command, go to IDLE.
  - Command letter: complete the current command and start the new one in the same cycle. This keeps "A10W5E" legal.
  - BAD: ERR_BADCHAR, drop the command, go to IDLE.
- State DISCARD: ignore digits and BAD bytes without further errors.
  - Terminator: go to IDLE.
  - Command letter: start the new command, go to ACCUM.
- Completing a command:
  - If the output register is free, or is handing off in this same cycle (o_cmd_valid && i_cmd_ready), load {cmd, acc, count} into it.
  - Otherwise raise ERR_OVERRUN and drop the new command. The held output is untouched.
- Timeout (TIMEOUT_CYC > 0):
  - The counter runs in ACCUM/DISCARD and clears on every i_rx_stb.
  - When it reaches TIMEOUT_CYC: ERR_TIMEOUT, drop the partial command, go to IDLE.
  - If a byte arrives in the expiry cycle, the byte wins.
- Error codes: BADCHAR=1, OVERFLOW=2, OVERRUN=3, ORPHAN=4, TIMEOUT=5.

## Timing
- Reset values: o_cmd_valid=0, o_cmd=0, o_cmd_word=0, o_cmd_ndigits=0, o_err_stb=0, o_err_code=0, o_busy=0. The state goes to IDLE and the accumulator and timeout counter clear.
- Reset mid-command or while o_cmd_valid is held drops everything with no error pulse.
- Bytes are decoded combinationally and the state updates on the i_rx_stb edge.
- o_cmd_valid rises one cycle after the terminating byte's strobe.
- o_err_stb fires one cycle after the offending byte's strobe, or one cycle after timeout expiry.
- Handshake:
  - The transfer occurs on an edge where o_cmd_valid && i_cmd_ready.
  - o_cmd_valid and the payload stay stable until the transfer.
  - o_cmd_valid never depends combinationally on i_cmd_ready.
- Back-to-back i_rx_stb on every cycle is supported.
- Accumulation continues while an output is pending, giving one command of buffering.
- At most one error is reported per byte.

## Structure
- uart_cmd_pkg holds:
  - cmd_e (3-bit enum).
  - err_e (3-bit enum).
  - ASCII constants: digits, command letters, 'E', CR, LF, space.
  - The byte-class enum {DIGIT, CMD, TERM, SPACE, BAD}.
- Sub-module uart_cmd_classify: a purely combinational byte decoder producing the byte class, nibble and command code. It is reusable by a future response encoder.
- The parser holds the FSM, accumulator, timeout counter and output register.

## Test plan
- DATA_W=32: "A1234abcdE" -> o_cmd=ADDR, word=0x1234ABCD, ndigits=8, o_cmd_valid one cycle after 'E'. Also send "R\r" -> READ, word=0, ndigits=0.
- "A10W5E" with i_cmd_ready tied high -> two commands: ADDR/0x10, then WRITE/0x5 on the cycle after 'W' and after 'E'; no errors.
- DATA_W=16: "W12345E" -> ERR_OVERFLOW on the 5th digit and no command. A following "R7E" -> READ/0x7.
- Hold i_cmd_ready low and send "R1E" then "R2E" -> the first command is held, ERR_OVERRUN after the second 'E'. Raising ready then transfers READ/0x1 only.
- "Wx" -> ERR_BADCHAR and return to IDLE; "5" in IDLE -> ERR_ORPHAN. LF, CR and space in IDLE produce no error.
- TIMEOUT_CYC=100: send "A12", then silence -> ERR_TIMEOUT exactly 100 cycles after '2'. Assert i_reset mid-"W3" -> all outputs 0, next "R1E" decodes normally.
